// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush controller for the 5-stage pipeline with a memory-wait FSM
// Define PIPE_CTRL_PERF_EN to build the stall/load-use/flush performance counters.
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_redirect,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        if_id_flush,
    output logic        id_ex_en,
    output logic        id_ex_flush,
    output logic        ex_mem_en,
    output logic        mem_wb_flush,
    output logic        mem_busy,
    output logic        mem_fault,
    output logic [31:0] stall_cycles,
    output logic [31:0] loaduse_count,
    output logic [31:0] flush_count
);
    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        fault_q, fault_d;
    logic        in_wait, timeout_hit, mem_stall, load_use;

    assign in_wait     = state_q == MEM_WAIT;
    assign timeout_hit = in_wait & (cnt_q == 16'(MEM_TIMEOUT - 1)) & ~mem_ready;
    assign mem_stall   = (~in_wait & mem_req & ~mem_ready) | (in_wait & ~mem_ready & ~timeout_hit);
    assign load_use    = ex_mem_read & (ex_rd != 5'd0) &
                         ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
    assign mem_busy    = rstn & in_wait;
    assign mem_fault   = fault_q;

    // Pipeline control: reset bubbles, then memory stall > redirect > load-use > run
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_en    = 1'b1;
        mem_wb_flush = 1'b0;
        if (!rstn) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (mem_stall) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (ex_redirect) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
        end else if (load_use) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_flush  = 1'b1;
        end
    end

    // Memory-wait FSM next state, timeout counter and sticky fault
    always_comb begin
        state_d = state_q;
        cnt_d   = 16'd0;
        fault_d = fault_q | timeout_hit;
        case (state_q)
            RUN:      state_d = (mem_req & ~mem_ready) ? MEM_WAIT : RUN;
            MEM_WAIT: begin
                cnt_d   = cnt_q + 16'd1;
                state_d = (mem_ready | timeout_hit) ? RUN : MEM_WAIT;
            end
            default:  state_d = RUN;
        endcase
    end

    // FSM state, timeout counter and fault registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= RUN;
            cnt_q   <= 16'd0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_q, stall_d, lu_q, lu_d, fl_q, fl_d;

    assign stall_d = stall_q + {31'd0, ~pc_en};
    assign lu_d    = lu_q + {31'd0, ~mem_stall & ~ex_redirect & load_use};
    assign fl_d    = fl_q + {31'd0, ~mem_stall & ex_redirect};

    assign stall_cycles  = stall_q;
    assign loaduse_count = lu_q;
    assign flush_count   = fl_q;

    // Free-running wrapping perf counters
    always_ff @(posedge clk) begin
        if (!rstn) begin
            stall_q <= 32'd0;
            lu_q    <= 32'd0;
            fl_q    <= 32'd0;
        end else begin
            stall_q <= stall_d;
            lu_q    <= lu_d;
            fl_q    <= fl_d;
        end
    end
`else
    assign stall_cycles  = 32'd0;
    assign loaduse_count = 32'd0;
    assign flush_count   = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scoreboard bench for pipe_hazard_ctrl (MEM_TIMEOUT=8)
module tb_pipe_hazard_ctrl;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic        id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, ex_mem_read = 1'b0;
    logic        ex_redirect = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
    logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush;
    logic        mem_busy, mem_fault;
    logic [31:0] stall_cycles, loaduse_count, flush_count;

    // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush, mem_busy}
    localparam logic [7:0] RST = 8'b00101010;
    localparam logic [7:0] N   = 8'b11010100;
    localparam logic [7:0] NB  = 8'b11010101;
    localparam logic [7:0] R   = 8'b11111100;
    localparam logic [7:0] RB  = 8'b11111101;
    localparam logic [7:0] L   = 8'b00011100;
    localparam logic [7:0] S   = 8'b00000010;
    localparam logic [7:0] SW  = 8'b00000011;

    typedef struct {
        logic [7:0]  ctl;
        logic        flt;
        logic [95:0] cnt;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] m_st = '0, m_lu = '0, m_fl = '0;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(8)) dut (
        .clk(clk), .rstn(rstn),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
        .mem_wb_flush(mem_wb_flush), .mem_busy(mem_busy), .mem_fault(mem_fault),
        .stall_cycles(stall_cycles), .loaduse_count(loaduse_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    // One cycle: drive at negedge, push expectation, sample mid-low-phase, then cross posedge
    task automatic step(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd, input logic mr,
                        input logic redir, input logic req, input logic rdy,
                        input logic [7:0] ectl, input logic eflt);
        exp_t x;
        logic [7:0]  octl;
        logic [95:0] ocnt;
        id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
        ex_rd = rd; ex_mem_read = mr; ex_redirect = redir; mem_req = req; mem_ready = rdy;
        x.ctl = ectl;
        x.flt = eflt;
`ifdef PIPE_CTRL_PERF_EN
        x.cnt = {m_st, m_lu, m_fl};
`else
        x.cnt = '0;
`endif
        sb.push_back(x);
        #2;
        octl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush, mem_busy};
        ocnt = {stall_cycles, loaduse_count, flush_count};
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            assert ({octl, mem_fault} === {e.ctl, e.flt}) else begin
                failures++;
                $error("FAIL %s ctl/fault got %b/%b expected %b/%b", tag, octl, mem_fault, e.ctl, e.flt);
            end
            checks++;
            assert (ocnt === e.cnt) else begin
                failures++;
                $error("FAIL %s counters got %h expected %h", tag, ocnt, e.cnt);
            end
        end
        if (!rstn) begin
            m_st = '0; m_lu = '0; m_fl = '0;
        end else begin
            m_st = m_st + {31'd0, ~ectl[7]};
            m_lu = m_lu + {31'd0, ~ectl[7] & ectl[2]};
            m_fl = m_fl + {31'd0, ectl[7] & ectl[5]};
        end
        @(negedge clk);
    endtask

    task automatic idle(input string tag, input logic [7:0] ectl, input logic eflt);
        step(tag, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ectl, eflt);
    endtask

    task automatic mem(input string tag, input logic redir, input logic req, input logic rdy,
                       input logic [7:0] ectl, input logic eflt);
        step(tag, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, redir, req, rdy, ectl, eflt);
    endtask

    initial begin
        @(negedge clk);
        for (int i = 0; i < 3; i++) idle("reset", RST, 1'b0);
        rstn = 1'b1;
        idle("run", N, 1'b0);
        step("lu_rs2", 5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, L, 1'b0);
        step("lu_rd0", 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, N, 1'b0);
        step("lu_rs1", 5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, L, 1'b0);
        step("lu_unused", 5'd7, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, N, 1'b0);
        step("lu_noload", 5'd9, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, N, 1'b0);
        mem("redirect", 1'b1, 1'b0, 1'b0, R, 1'b0);
        step("redir_lu", 5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, R, 1'b0);
        idle("run2", N, 1'b0);
        mem("wait1", 1'b0, 1'b1, 1'b0, S, 1'b0);
        mem("wait2", 1'b0, 1'b1, 1'b0, SW, 1'b0);
        step("wait3_lu", 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, SW, 1'b0);
        mem("wait4", 1'b0, 1'b1, 1'b0, SW, 1'b0);
        mem("wait_rel", 1'b0, 1'b1, 1'b1, NB, 1'b0);
        idle("after_wait", N, 1'b0);
        mem("wr1", 1'b1, 1'b1, 1'b0, S, 1'b0);
        mem("wr2", 1'b1, 1'b1, 1'b0, SW, 1'b0);
        mem("wr_rel", 1'b1, 1'b1, 1'b1, RB, 1'b0);
        mem("single", 1'b0, 1'b1, 1'b1, N, 1'b0);
        idle("single_after", N, 1'b0);
        mem("rdy8_s", 1'b0, 1'b1, 1'b0, S, 1'b0);
        for (int i = 0; i < 7; i++) mem("rdy8_w", 1'b0, 1'b1, 1'b0, SW, 1'b0);
        mem("rdy8_rel", 1'b0, 1'b1, 1'b1, NB, 1'b0);
        idle("rdy8_nofault", N, 1'b0);
        mem("to_s", 1'b0, 1'b1, 1'b0, S, 1'b0);
        for (int i = 0; i < 7; i++) mem("to_w", 1'b0, 1'b1, 1'b0, SW, 1'b0);
        mem("to_hit", 1'b0, 1'b1, 1'b0, NB, 1'b0);
        idle("to_fault", N, 1'b1);
        idle("to_sticky", N, 1'b1);
        mem("mid_s", 1'b0, 1'b1, 1'b0, S, 1'b1);
        mem("mid_w", 1'b0, 1'b1, 1'b0, SW, 1'b1);
        rstn = 1'b0;
        mem("mid_rst", 1'b0, 1'b1, 1'b0, RST, 1'b1);
        rstn = 1'b1;
        idle("post_rst", N, 1'b0);
        idle("post_rst2", N, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage RISC-V pipeline.
- Drives the enable and flush (bubble-insert) inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC enable.
- Sequences multi-cycle data-memory accesses with a wait FSM, detects load-use hazards, and applies taken-branch/jump flushes.
- Sits in the CPU top beside the forwarding unit; all its outputs feed pipeline-register controls combinationally.

Parameters:
- MEM_TIMEOUT, 255, max cycles spent in MEM_WAIT before the fault is raised and the stall is released (range 1..65535).

Ports:
- clk  in  1  clock
- rstn  in  1  reset
- id_rs1  in  5  source reg 1 of the instruction in ID
- id_rs2  in  5  source reg 2 of the instruction in ID
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- ex_rd  in  5  destination reg of the instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_redirect  in  1  EX has a taken branch or jump (PC redirect)
- mem_req  in  1  MEM instruction is a load/store
- mem_ready  in  1  data memory completes the access this cycle
- pc_en  out  1  PC update enable
- if_id_en  out  1  IF/ID load enable
- if_id_flush  out  1  IF/ID bubble insert
- id_ex_en  out  1  ID/EX load enable
- id_ex_flush  out  1  ID/EX bubble insert
- ex_mem_en  out  1  EX/MEM load enable
- mem_wb_flush  out  1  MEM/WB bubble insert (reg_write=0)
- mem_busy  out  1  FSM in MEM_WAIT
- mem_fault  out  1  sticky memory timeout flag
- stall_cycles  out  32  perf: cycles with pc_en=0
- loaduse_count  out  32  perf: load-use bubbles inserted
- flush_count  out  32  perf: redirect flushes applied

Behaviour:
- Reset: rstn is synchronous, active-low; clk is the clock. While rstn=0: state←RUN, timeout counter←0, mem_fault←0, perf counters←0. Outputs during reset: pc_en=0, all *_en=0, all *_flush=1, mem_busy=0.
- FSM states: RUN, MEM_WAIT. State is registered; stall/flush outputs are combinational from state and inputs (zero-cycle latency).
- mem_stall = (state==RUN & mem_req & ~mem_ready) | (state==MEM_WAIT & ~mem_ready & ~timeout_hit).
- RUN→MEM_WAIT when mem_req & ~mem_ready. MEM_WAIT→RUN on mem_ready or timeout_hit. RUN stays in RUN when mem_req & mem_ready (single-cycle access).
- Timeout counter: cleared on entering MEM_WAIT, increments each MEM_WAIT cycle. timeout_hit = (cnt == MEM_TIMEOUT-1) & ~mem_ready. On timeout_hit, mem_fault←1 (sticky until reset) and the stall is released that cycle. mem_ready takes precedence if both occur on the same cycle: no fault.
- load_use = ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Priority, highest first:
  - mem_stall: pc_en=if_id_en=id_ex_en=ex_mem_en=0, mem_wb_flush=1, other flushes 0. ex_redirect and load_use are ignored, because EX is frozen and re-presents them later.
  - ex_redirect: all en=1, if_id_flush=1, id_ex_flush=1.
  - load_use: pc_en=if_id_en=0, id_ex_flush=1, ex_mem_en=1.
  - Otherwise: all en=1, all flushes 0.
- mem_busy = (state==MEM_WAIT).
- ex_redirect and load_use cannot both legitimately be true. If they are, redirect wins.
- Perf counters, per cycle with rstn=1:
  - stall_cycles increments when pc_en=0.
  - loaduse_count increments when the load_use branch is taken.
  - flush_count increments when the redirect branch is taken.
  - All counters wrap at 2^32.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- Defined: the three 32-bit perf counters are implemented as described.
- Undefined: no counter flops are built, and stall_cycles, loaduse_count and flush_count are tied to 0. Ports are unchanged.

Test Plan:
- Reset: hold rstn=0 for 3 cycles → pc_en=0, if_id_flush=id_ex_flush=mem_wb_flush=1; release → state RUN, all en=1, flushes 0, mem_fault=0.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 for 1 cycle → pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1; loaduse_count 0→1. Same stimulus with ex_rd=0 → no stall.
- Redirect: ex_redirect=1 → if_id_flush=id_ex_flush=1, pc_en=1; flush_count +1.
- Memory wait: mem_req=1, mem_ready=0 for 4 cycles then 1 → mem_busy high on cycles 2–5; pc_en/if_id_en/id_ex_en/ex_mem_en=0 and mem_wb_flush=1 for 4 cycles; released on the mem_ready cycle; stall_cycles=4. A simultaneous ex_redirect during the wait produces no flush until release.
- Timeout: MEM_TIMEOUT=8, mem_req=1, mem_ready never asserted → stall released after 8 stall cycles and mem_fault=1 until rstn=0. mem_ready arriving on the 8th cycle → no fault.
- Reset mid-wait: rstn=0 while in MEM_WAIT → next cycle state RUN, counters 0, mem_fault 0.
